// File: rtl/vga_rd_scheduler.sv
// vga_rd_scheduler
// Walks one frame of RGB565 pixels out of the SDRAM frame buffer into the
// display FIFO, one burst at a time. The FIFO must have room for a full
// burst before a request is issued. At each VGA frame start the newest
// completed ping-pong bank is latched, the FIFO is flushed, and the walk
// restarts at that bank's base. Display underflow cycles are counted.
module vga_rd_scheduler #(
  parameter int H_ACT       = 800,
  parameter int V_ACT       = 480,
  parameter int BURST_LEN   = 256,
  parameter int FIFO_DEPTH  = 1024,
  parameter int ADDR_W      = 22,
  parameter int BANK_STRIDE = 524288,
  parameter int CLR_CYCLES  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              frame_start,
  input  logic              wr_frame_done,
  input  logic              wr_bank,
  input  logic [10:0]       fifo_wr_count,
  input  logic              pix_rd_en,
  input  logic              fifo_empty,
  output logic              fifo_clr,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [8:0]        rd_len,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic              rd_bank,
  output logic              frame_busy,
  output logic [15:0]       underflow_cnt
);

  localparam int FRAME_PIX = H_ACT * V_ACT;
  // remaining must also be able to represent BURST_LEN for the min() compare
  localparam int REM_W0    = $clog2(FRAME_PIX + 1);
  localparam int REM_W     = (REM_W0 > 10) ? REM_W0 : 10;
  localparam int CNT_W     = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  localparam logic [ADDR_W-1:0] BANK1_BASE  = ADDR_W'(BANK_STRIDE);
  localparam logic [REM_W-1:0]  FRAME_PIX_R = REM_W'(FRAME_PIX);
  localparam logic [REM_W-1:0]  BURST_R     = REM_W'(BURST_LEN);
  localparam logic [8:0]        BURST_LEN_R = 9'(BURST_LEN);
  // Room check rewritten as count <= DEPTH - BURST so the sum cannot overflow
  localparam logic [11:0]       ROOM_LIMIT  = 12'(FIFO_DEPTH - BURST_LEN);
  localparam logic [CNT_W-1:0]  CLR_LOAD    = CNT_W'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT,
    S_REQ,
    S_XFER
  } state_t;

  state_t           state;
  logic             latest_bank;
  logic             pending;
  logic [REM_W-1:0] remaining;
  logic [CNT_W-1:0] clr_cnt;
  logic             enter_clr;
  logic             fifo_room;

  assign fifo_room  = ({1'b0, fifo_wr_count} <= ROOM_LIMIT);
  assign frame_busy = (state != S_IDLE);

  // Decide when the FSM (re)starts a frame flush this cycle
  always_comb begin
    enter_clr = 1'b0;
    case (state)
      S_IDLE, S_CLEAR, S_WAIT: enter_clr = frame_start;
      S_REQ:                   enter_clr = frame_start && !rd_ack;
      S_XFER:                  enter_clr = rd_done && (pending || frame_start);
      default:                 enter_clr = 1'b0;
    endcase
  end

  // Track the bank of the most recently completed writer frame
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      latest_bank <= 1'b0;
    end else if (wr_frame_done) begin
      latest_bank <= wr_bank;
    end
  end

  // Frame read sequencer: flush, wait for room, request, transfer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      fifo_clr  <= 1'b0;
      rd_req    <= 1'b0;
      rd_bank   <= 1'b0;
      pending   <= 1'b0;
      rd_addr   <= '0;
      rd_len    <= '0;
      remaining <= '0;
      clr_cnt   <= '0;
    end else if (enter_clr) begin
      state     <= S_CLEAR;
      fifo_clr  <= 1'b1;
      clr_cnt   <= CLR_LOAD;
      rd_req    <= 1'b0;
      rd_bank   <= latest_bank;
      rd_addr   <= latest_bank ? BANK1_BASE : '0;
      remaining <= FRAME_PIX_R;
      pending   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          fifo_clr <= 1'b0;
          rd_req   <= 1'b0;
        end
        S_CLEAR: begin
          if (clr_cnt == '0) begin
            fifo_clr <= 1'b0;
            state    <= S_WAIT;
          end else begin
            clr_cnt <= clr_cnt - 1'b1;
          end
        end
        S_WAIT: begin
          if (remaining == '0) begin
            state <= S_IDLE;
          end else if (fifo_room) begin
            rd_len <= (remaining >= BURST_R) ? BURST_LEN_R : remaining[8:0];
            rd_req <= 1'b1;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (rd_ack) begin
            rd_req <= 1'b0;
            state  <= S_XFER;
            if (frame_start) begin
              pending <= 1'b1;
            end
          end
        end
        S_XFER: begin
          if (rd_done) begin
            rd_addr   <= rd_addr + ADDR_W'(rd_len);
            remaining <= remaining - REM_W'(rd_len);
            state     <= S_WAIT;
          end else if (frame_start) begin
            pending <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          fifo_clr <= 1'b0;
          rd_req   <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles where the pixel path reads an empty FIFO
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      underflow_cnt <= 16'h0000;
    end else if (pix_rd_en && fifo_empty && (underflow_cnt != 16'hFFFF)) begin
      underflow_cnt <= underflow_cnt + 16'h0001;
    end
  end

endmodule

// File: doc/vga_rd_scheduler.md
Name: vga_rd_scheduler

Overview:
- Sequences frame-buffer reads from the SDRAM controller into the display FIFO that feeds the VGA pixel path.
- Issues burst read requests only when the FIFO has room, walking linearly through one frame of RGB565 pixels per VGA frame.
- Selects the most recently completed ping-pong bank at each frame start, flushes the FIFO, and counts display underflows.

Parameters:
- H_ACT, 800, active pixels per line
- V_ACT, 480, active lines per frame
- BURST_LEN, 256, maximum pixels per read burst
- FIFO_DEPTH, 1024, display FIFO depth in pixels
- ADDR_W, 22, SDRAM word-address width
- BANK_STRIDE, 524288, address offset between bank 0 and bank 1
- CLR_CYCLES, 4, fifo_clr pulse length in cycles

Ports:
- CLK  in  1  pixel/system clock
- RST  in  1  asynchronous reset, active-high
- frame_start  in  1  one-cycle pulse at VGA vertical blank start
- wr_frame_done  in  1  one-cycle pulse: writer finished a frame
- wr_bank  in  1  bank written by the just-finished frame; sampled with wr_frame_done
- fifo_wr_count  in  11  display FIFO fill level (write side)
- pix_rd_en  in  1  VGA path reading the FIFO this cycle
- fifo_empty  in  1  display FIFO empty
- fifo_clr  out  1  synchronous FIFO flush
- rd_req  out  1  burst read request
- rd_addr  out  ADDR_W  burst start word address
- rd_len  out  9  burst length in pixels, 1..BURST_LEN
- rd_ack  in  1  SDRAM controller accepted request
- rd_done  in  1  last word of the accepted burst written to FIFO
- rd_bank  out  1  bank currently being displayed
- frame_busy  out  1  frame transfer in progress (not IDLE)
- underflow_cnt  out  16  saturating count of pix_rd_en && fifo_empty cycles

Behaviour:
- Reset (async, RST=1):
  - state IDLE
  - fifo_clr, rd_req, frame_busy, rd_bank, latest_bank, pending = 0
  - rd_addr, rd_len, underflow_cnt = 0
  - remaining = 0
- FRAME_PIX = H_ACT*V_ACT. remaining is wide enough to hold FRAME_PIX.
- latest_bank <= wr_bank on every wr_frame_done, in any state.
- State IDLE: on frame_start -> CLEAR.
- State CLEAR:
  - fifo_clr=1 for exactly CLR_CYCLES cycles.
  - On entry: rd_bank <= latest_bank; rd_addr <= rd_bank_new*BANK_STRIDE; remaining <= FRAME_PIX; pending <= 0.
  - Then -> WAIT.
- State WAIT:
  - If remaining==0 -> IDLE.
  - Else if fifo_wr_count + BURST_LEN <= FIFO_DEPTH: rd_len <= min(BURST_LEN, remaining), -> REQ.
- State REQ:
  - rd_req=1; rd_addr and rd_len held stable until rd_ack.
  - On rd_ack: rd_req deasserts the next cycle, -> XFER.
- State XFER: on rd_done: rd_addr += rd_len (wrap mod 2^ADDR_W); remaining -= rd_len; then -> CLEAR if pending, else -> WAIT.
- frame_start handling:
  - In WAIT, REQ (no ack this cycle), or CLEAR: abort to CLEAR next cycle and drop rd_req. In CLEAR this restarts the CLR_CYCLES count.
  - In XFER: set pending; the outstanding burst must complete before the flush.
  - frame_start and rd_ack in the same REQ cycle: ack wins -> XFER with pending=1.
- frame_start while remaining>0 (previous frame incomplete) is legal; the new frame replaces it.
- wr_frame_done mid-frame does not change rd_bank until the next CLEAR.
- frame_busy = (state != IDLE).
- underflow_cnt increments when pix_rd_en && fifo_empty, saturates at 16'hFFFF, and is cleared only by RST.
- Never more than one request outstanding; rd_done outside XFER is ignored.

Test Plan:
- Reset, wr_frame_done with wr_bank=1, then frame_start, fifo_wr_count=0 -> fifo_clr high 4 cycles, rd_bank=1, first rd_req with rd_addr=524288, rd_len=256.
- Ack/done every burst with FIFO held at 0 -> exactly 1500 bursts, addresses incrementing by 256, last rd_addr=524288+383744; then IDLE, frame_busy=0.
- Hold fifo_wr_count=769 -> no rd_req. Drop it to 768 -> rd_req asserts 2 cycles later (WAIT then REQ).
- H_ACT=10, V_ACT=30 (300 pixels) -> bursts of rd_len 256 then 44.
- frame_start during XFER -> no fifo_clr until rd_done; then CLEAR and restart at the bank base. frame_start and rd_ack in the same cycle -> XFER, then CLEAR after rd_done.
- pix_rd_en=1 with fifo_empty=1 for 70000 cycles -> underflow_cnt=65535. Assert RST mid-burst -> all outputs 0 immediately, without waiting for a clock edge.
